// File: rtl/ui_input_controller_pkg.sv
// Shared definitions for the UI input controller: register map, CTRL bit layout
// and the per-device ready/overrun/ie status update rule.
package ui_input_controller_pkg;

  localparam logic [1:0] UI_KDATA = 2'd0;
  localparam logic [1:0] UI_KCTRL = 2'd1;
  localparam logic [1:0] UI_SDATA = 2'd2;
  localparam logic [1:0] UI_SCTRL = 2'd3;

  localparam int unsigned CTRL_READY = 0;
  localparam int unsigned CTRL_OVR   = 2;
  localparam int unsigned CTRL_IE    = 4;

  localparam int unsigned NUM_KEYS = 4;
  localparam int unsigned NUM_SW   = 10;

  typedef struct packed {
    logic ready;
    logic ovr;
    logic ie;
  } ctrl_t;

  function automatic logic [4:0] ctrl_word(input ctrl_t c);
    logic [4:0] w;
    w             = '0;
    w[CTRL_READY] = c.ready;
    w[CTRL_OVR]   = c.ovr;
    w[CTRL_IE]    = c.ie;
    return w;
  endfunction

  // The CTRL write lands first; the event rules then see the written overrun.
  function automatic ctrl_t next_ctrl(input ctrl_t cur, input logic wr, input logic wr_ovr,
                                      input logic wr_ie, input logic rd, input logic evt);
    ctrl_t n;
    n = cur;
    if (wr) begin
      if (!wr_ovr) n.ovr = 1'b0;
      n.ie = wr_ie;
    end
    if (evt && !rd) begin
      n.ready = 1'b1;
      if (cur.ready) n.ovr = 1'b1;
    end else if (rd && !evt) begin
      n.ready = 1'b0;
    end
    return n;
  endfunction

endpackage

// File: rtl/ui_debounce_bit.sv
// Single-bit two-flop synchroniser plus debouncer; changed pulses in the cycle
// the new value is accepted into stable.
module ui_debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned CNT_BITS        = 15,
  parameter logic        RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic changed
);

  localparam logic [CNT_BITS-1:0] CntMax = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic                sync1_q, sync2_q;
  logic                stable_q, stable_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    changed  = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      changed  = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  // Synchroniser also resets to the idle level so no stale edge survives reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= RESET_VAL;
      sync2_q  <= RESET_VAL;
      stable_q <= RESET_VAL;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/ui_input_controller.sv
// Memory-mapped KEYS/SWITCHES input device: debounced data registers, sticky
// ready/overrun status per device and a registered interrupt request.
module ui_input_controller
  import ui_input_controller_pkg::*;
#(
  parameter int unsigned DBITS           = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned CNT_BITS        = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       addr,
  input  logic             rdEn,
  input  logic             wrtEn,
  input  logic [DBITS-1:0] in,
  output logic [DBITS-1:0] out,
  input  logic [3:0]       KEYS,
  input  logic [9:0]       SWITCHES,
  output logic             intr
);

  logic [NUM_KEYS-1:0] key_stable, key_chg;
  logic [NUM_SW-1:0]   sw_stable, sw_chg;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    ui_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_BITS       (CNT_BITS),
      .RESET_VAL      (1'b1)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .raw    (KEYS[i]),
      .stable (key_stable[i]),
      .changed(key_chg[i])
    );
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    ui_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_BITS       (CNT_BITS),
      .RESET_VAL      (1'b0)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .raw    (SWITCHES[i]),
      .stable (sw_stable[i]),
      .changed(sw_chg[i])
    );
  end

  ctrl_t kctrl_q, kctrl_d, sctrl_q, sctrl_d;
  logic  intr_q;
  logic  k_rd, k_wr, s_rd, s_wr;

  assign k_rd = rdEn && (addr == UI_KDATA);
  assign s_rd = rdEn && (addr == UI_SDATA);
  assign k_wr = wrtEn && (addr == UI_KCTRL);
  assign s_wr = wrtEn && (addr == UI_SCTRL);

  always_comb begin
    kctrl_d = next_ctrl(kctrl_q, k_wr, in[CTRL_OVR], in[CTRL_IE], k_rd, |key_chg);
    sctrl_d = next_ctrl(sctrl_q, s_wr, in[CTRL_OVR], in[CTRL_IE], s_rd, |sw_chg);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kctrl_q <= '0;
      sctrl_q <= '0;
      intr_q  <= 1'b0;
    end else begin
      kctrl_q <= kctrl_d;
      sctrl_q <= sctrl_d;
      intr_q  <= (kctrl_q.ready & kctrl_q.ie) | (sctrl_q.ready & sctrl_q.ie);
    end
  end

  assign intr = intr_q;

  // Read data reflects current register contents, i.e. the pre-update value.
  always_comb begin
    out = '0;
    case (addr)
      UI_KDATA: out[NUM_KEYS-1:0] = ~key_stable;
      UI_KCTRL: out[4:0]          = ctrl_word(kctrl_q);
      UI_SDATA: out[NUM_SW-1:0]   = sw_stable;
      UI_SCTRL: out[4:0]          = ctrl_word(sctrl_q);
      default:  out               = '0;
    endcase
  end

  logic unused_in;
  assign unused_in = ^{in[DBITS-1:5], in[3], in[1:0]};

endmodule

// File: tb/tb_ui_input_controller.sv
// Bench for ui_input_controller: directed scenarios with literal expectations,
// then random traffic compared every cycle against a behavioural model.
module tb_ui_input_controller;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        rdEn, wrtEn;
  logic [31:0] in, out;
  logic [3:0]  KEYS;
  logic [9:0]  SWITCHES;
  logic        intr;

  int n_checks = 0;
  int n_fail   = 0;

  ui_input_controller #(
    .DBITS          (32),
    .DEBOUNCE_CYCLES(D),
    .CNT_BITS       (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .rdEn    (rdEn),
    .wrtEn   (wrtEn),
    .in      (in),
    .out     (out),
    .KEYS    (KEYS),
    .SWITCHES(SWITCHES),
    .intr    (intr)
  );

  always #5 clk = ~clk;

  // Model: each raw bit reaches the debouncer two samples late; a value is
  // accepted once it has differed from the accepted value on D samples in a row.
  bit [3:0] mk_p1, mk_p2, mk_st;
  bit [9:0] ms_p1, ms_p2, ms_st;
  int       mk_run[4];
  int       ms_run[10];
  bit       m_krdy, m_kovr, m_kie, m_srdy, m_sovr, m_sie, m_intr;
  bit       model_valid = 1'b0;

  task automatic status(input bit rdy, input bit ovr, input bit ie, input bit wr,
                        input bit w_ovr, input bit w_ie, input bit rd, input bit ev,
                        output bit n_rdy, output bit n_ovr, output bit n_ie);
    n_rdy = rdy;
    n_ovr = (wr && !w_ovr) ? 1'b0 : ovr;
    n_ie  = wr ? w_ie : ie;
    if (ev && !rd) begin
      n_rdy = 1'b1;
      if (rdy) n_ovr = 1'b1;
    end else if (rd && !ev) begin
      n_rdy = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    bit kev, sev, nintr;
    if (reset) begin
      mk_p1 = 4'hF; mk_p2 = 4'hF; mk_st = 4'hF;
      ms_p1 = '0;   ms_p2 = '0;   ms_st = '0;
      for (int i = 0; i < 4; i++) mk_run[i] = 0;
      for (int i = 0; i < 10; i++) ms_run[i] = 0;
      {m_krdy, m_kovr, m_kie, m_srdy, m_sovr, m_sie, m_intr} = '0;
      model_valid = 1'b1;
    end else begin
      kev = 1'b0;
      sev = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (mk_p2[i] != mk_st[i]) begin
          mk_run[i]++;
          if (mk_run[i] == D) begin mk_st[i] = mk_p2[i]; mk_run[i] = 0; kev = 1'b1; end
        end else mk_run[i] = 0;
      end
      for (int i = 0; i < 10; i++) begin
        if (ms_p2[i] != ms_st[i]) begin
          ms_run[i]++;
          if (ms_run[i] == D) begin ms_st[i] = ms_p2[i]; ms_run[i] = 0; sev = 1'b1; end
        end else ms_run[i] = 0;
      end
      mk_p2 = mk_p1; mk_p1 = KEYS;
      ms_p2 = ms_p1; ms_p1 = SWITCHES;
      nintr = (m_krdy & m_kie) | (m_srdy & m_sie);
      status(m_krdy, m_kovr, m_kie, wrtEn && addr == 2'd1, in[2], in[4],
             rdEn && addr == 2'd0, kev, m_krdy, m_kovr, m_kie);
      status(m_srdy, m_sovr, m_sie, wrtEn && addr == 2'd3, in[2], in[4],
             rdEn && addr == 2'd2, sev, m_srdy, m_sovr, m_sie);
      m_intr = nintr;
    end
  end

  function automatic logic [31:0] model_out(input logic [1:0] a);
    case (a)
      2'd0:    return {28'b0, ~mk_st};
      2'd1:    return {27'b0, m_kie, 1'b0, m_kovr, 1'b0, m_krdy};
      2'd2:    return {22'b0, ms_st};
      default: return {27'b0, m_sie, 1'b0, m_sovr, 1'b0, m_srdy};
    endcase
  endfunction

  always @(negedge clk) begin
    if (model_valid) begin
      n_checks++;
      if (out !== model_out(addr)) begin
        n_fail++;
        $display("FAIL model_out t=%0t addr=%0d got=%h exp=%h", $time, addr, out,
                 model_out(addr));
      end
      n_checks++;
      if (intr !== m_intr) begin
        n_fail++;
        $display("FAIL model_intr t=%0t got=%b exp=%b", $time, intr, m_intr);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, out, exp);
  endtask

  initial begin
    reset = 1'b1; addr = '0; rdEn = 1'b0; wrtEn = 1'b0; in = '0;
    KEYS = 4'hF; SWITCHES = '0;
    repeat (3) tick;
    reset = 1'b0;
    for (int a = 0; a < 4; a++) rd_chk("reset_read", 2'(a), 32'h0);
    chk("reset_intr", {31'b0, intr}, 32'h0);

    // Key press accepted exactly D+2 edges after the raw edge
    KEYS = 4'hE;
    repeat (5) tick;
    rd_chk("kdata_early", 2'd0, 32'h0);
    tick;
    rd_chk("kdata_pressed", 2'd0, 32'h1);
    rd_chk("kctrl_ready", 2'd1, 32'h1);
    rdEn = 1'b1;
    rd_chk("kdata_read", 2'd0, 32'h1);
    tick;
    rdEn = 1'b0;
    rd_chk("kctrl_consumed", 2'd1, 32'h0);

    // Short switch glitch is discarded
    SWITCHES = 10'h008;
    repeat (3) tick;
    SWITCHES = '0;
    for (int i = 0; i < 20; i++) begin
      rd_chk((i % 2) ? "sctrl_glitch" : "sdata_glitch", (i % 2) ? 2'd3 : 2'd2, 32'h0);
      tick;
    end

    // Two unread switch events give overrun; write enables interrupt, clears overrun
    SWITCHES = 10'h001;
    repeat (10) tick;
    SWITCHES = 10'h003;
    repeat (10) tick;
    rd_chk("sctrl_overrun", 2'd3, 32'h5);
    rd_chk("sdata_settled", 2'd2, 32'h3);
    addr = 2'd3; in = 32'h10; wrtEn = 1'b1;
    tick;
    wrtEn = 1'b0; in = '0;
    rd_chk("sctrl_written", 2'd3, 32'h11);
    chk("intr_lag", {31'b0, intr}, 32'h0);
    tick;
    chk("intr_set", {31'b0, intr}, 32'h1);

    // Key event coinciding with a KDATA read while ready
    KEYS = 4'hF;
    repeat (6) tick;
    rd_chk("kctrl_release", 2'd1, 32'h1);
    KEYS = 4'hE;
    repeat (5) tick;
    rdEn = 1'b1;
    rd_chk("kdata_old_value", 2'd0, 32'h0);
    tick;
    rdEn = 1'b0;
    rd_chk("kctrl_no_overrun", 2'd1, 32'h1);
    rd_chk("kdata_new_value", 2'd0, 32'h1);

    // Reset in the middle of a debounce
    KEYS = 4'hF;
    repeat (2) tick;
    reset = 1'b1; KEYS = 4'hE;
    repeat (2) tick;
    reset = 1'b0;
    for (int a = 0; a < 4; a++) rd_chk("rst_mid_read", 2'(a), 32'h0);
    repeat (5) tick;
    rd_chk("rst_kdata_early", 2'd0, 32'h0);
    rd_chk("rst_kctrl_early", 2'd1, 32'h0);
    tick;
    rd_chk("rst_kdata", 2'd0, 32'h1);
    rd_chk("rst_kctrl", 2'd1, 32'h1);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 4) == 0) KEYS[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) SWITCHES[$urandom_range(0, 9)] ^= 1'b1;
      addr  = 2'($urandom_range(0, 3));
      rdEn  = ($urandom_range(0, 3) == 0);
      wrtEn = ($urandom_range(0, 5) == 0);
      in    = $urandom;
      reset = ($urandom_range(0, 499) == 0);
      tick;
    end
    reset = 1'b0; rdEn = 1'b0; wrtEn = 1'b0;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ui_input_controller.md
Name: ui_input_controller

Overview:
- Input-direction counterpart of the UI output device (LEDs/HEX): a memory-mapped responder that captures KEYS and SWITCHES for the processor.
- Synchronises and debounces every input bit, detects changes on the debounced values, and latches sticky ready/overrun status per device.
- Raises an interrupt request when enabled.
- Sits on the processor IO bus beside the LED/HEX output controller and shares its in/out data-bus style.

Parameters:
- DBITS, 32, data bus width.
- DEBOUNCE_CYCLES, 20000, number of consecutive cycles a synchronised input must differ from its stable value before it is accepted (minimum 2).
- CNT_BITS, 15, debounce counter width; must satisfy 2^CNT_BITS > DEBOUNCE_CYCLES.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- reset, input, 1, synchronous, active-high.
- addr, input, 2, register select: 0 KDATA, 1 KCTRL, 2 SDATA, 3 SCTRL.
- rdEn, input, 1, read strobe; only triggers read side effects.
- wrtEn, input, 1, write strobe.
- in, input, DBITS, write data.
- out, output, DBITS, read data; zero-extended.
- KEYS, input, 4, raw push buttons, active-low.
- SWITCHES, input, 10, raw slide switches, active-high.
- intr, output, 1, registered interrupt request.

Behaviour:
- Reset values:
  - Key stable values = 4'b1111 (released), so KDATA = 0.
  - Switch stable values = 0.
  - All debounce counters = 0.
  - All ready, overrun and ie bits = 0.
  - intr = 0.
- Debounce, per bit:
  - Two-flop synchroniser feeds the counter.
  - sync == stable: counter cleared to 0.
  - Otherwise counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing: stable <= sync, counter <= 0, and a one-cycle changed pulse is issued.
  - Latency: a clean raw edge is reflected in stable (and the DATA register) exactly DEBOUNCE_CYCLES+2 rising edges later.
  - Any glitch shorter than DEBOUNCE_CYCLES synchronised cycles is discarded.
- KDATA (read-only): bits[3:0] = ~key stable value (1 = pressed); upper bits 0.
- SDATA (read-only): bits[9:0] = switch stable value; upper bits 0.
- CTRL registers (KCTRL, SCTRL):
  - bit0 ready, read-only.
  - bit2 overrun; writing 0 clears it, writing 1 has no effect.
  - bit4 ie, read/write.
  - All other bits read 0 and ignore writes.
- Change event for a device: OR of its per-bit changed pulses; multiple bits changing in one cycle count as one event.
- Ready/overrun update each cycle, per device, with rdEn on DATA (addr 0 or 2) as the "read" condition:
  - event and not read: ready <= 1; if ready was already 1, overrun <= 1.
  - read and not event: ready <= 0.
  - read and event in the same cycle: ready stays 1, overrun unchanged (old value was consumed).
- Write vs event: a CTRL write in the same cycle as an event applies the write to overrun/ie first, then event rules apply. Overrun therefore ends 1 if ready was 1.
- out timing: combinational from addr with current register values, valid regardless of rdEn. Returned value is the pre-update value.
- Illegal accesses: wrtEn to DATA addresses is ignored. rdEn and wrtEn together on a CTRL address performs the write only.
- intr <= (kready & kie) | (sready & sie), registered one cycle after the status change.
- Reset mid-debounce discards partial counts; no event follows reset deassertion unless the input then differs from the reset stable value for the full debounce time.

Decomposition:
- Shared package/header (alongside the existing UI device defines):
  - Address constants UI_KDATA = 0, UI_KCTRL = 1, UI_SDATA = 2, UI_SCTRL = 3.
  - Bit positions CTRL_READY = 0, CTRL_OVR = 2, CTRL_IE = 4.
- One sub-module: ui_debounce_bit.
  - Parameters: DEBOUNCE_CYCLES, CNT_BITS, RESET_VAL.
  - Ports: clk, reset, raw, stable, changed.
  - Instantiated 4x for keys (RESET_VAL 1) and 10x for switches (RESET_VAL 0).

Test Plan (DEBOUNCE_CYCLES = 4):
- Reset with KEYS = 4'hF, SWITCHES = 0 -> out reads 0 at all four addresses; intr = 0.
- KEYS 4'hF -> 4'hE held -> KDATA = 0x1 and KCTRL = 0x1 exactly 6 edges later. Then rdEn at addr 0 -> out = 0x1 that cycle, KCTRL = 0x0 next cycle.
- SWITCHES[3] high for 3 cycles then low -> SDATA stays 0x000, SCTRL stays 0x0 for 20 cycles.
- SWITCHES -> 0x001 settles, then 0x003 settles, no reads -> SCTRL = 0x5. Write SCTRL = 0x10 -> SCTRL = 0x11 and intr = 1 on the following edge.
- Key change event coinciding with rdEn on KDATA while ready = 1 -> KCTRL = 0x1 (no overrun); out returns the old KDATA value.
- Assert reset 2 cycles into a key debounce, release with KEYS held 4'hE -> no event until 6 edges after release, then KDATA = 0x1.
